// File: rtl/commit_store_queue_pkg.sv
// Shared types and constants for the commit-side store queue.
//   PLEN        physical address width
//   STQ_DEPTH   default number of queue entries
//   stq_entry_t one buffered store: address, data, byte enables, log2 size
//   ST_*        drain FSM state encodings
package commit_store_queue_pkg;

  localparam int unsigned PLEN      = 56;
  localparam int unsigned STQ_DEPTH = 8;

  typedef struct packed {
    logic [PLEN-1:0] paddr;
    logic [63:0]     data;
    logic [7:0]      be;
    logic [1:0]      data_size;
  } stq_entry_t;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_ACK = 1'b1;

endpackage

// File: rtl/commit_store_queue.sv
// Store queue between the commit stage and the D$.
// Stores are pushed speculatively at execute, promoted to committed one at a
// time by commit_i, and drained to the D$ in order through a req/gnt/ack
// handshake.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       discard all speculative entries
//   valid_i, paddr_i, data_i,
//   be_i, data_size_i, ready_o    speculative push; accepted only when ready_o
//   commit_i, commit_ready_o      promote oldest speculative entry
//   no_st_pending_o, empty_o      status to commit (fences wait on no_st_pending_o)
//   page_offset_i,
//   page_offset_matches_o         possible store/load alias
//   req_o, addr_o, wdata_o, be_o,
//   size_o, gnt_i, ack_i          D$ write port
//
// Build option: COMMIT_STQ_ALIAS_CHECK_EN
//   defined     -> per-entry page offset comparators
//   not defined -> page_offset_matches_o = !empty_o
module commit_store_queue
  import commit_store_queue_pkg::*;
#(
  parameter int unsigned DEPTH = STQ_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [PLEN-1:0] paddr_i,
  input  logic [63:0]     data_i,
  input  logic [7:0]      be_i,
  input  logic [1:0]      data_size_i,
  output logic            ready_o,
  input  logic            commit_i,
  output logic            commit_ready_o,
  output logic            no_st_pending_o,
  output logic            empty_o,
  input  logic [11:0]     page_offset_i,
  output logic            page_offset_matches_o,
  output logic            req_o,
  output logic [PLEN-1:0] addr_o,
  output logic [63:0]     wdata_o,
  output logic [7:0]      be_o,
  output logic [1:0]      size_o,
  input  logic            gnt_i,
  input  logic            ack_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // head..cmt: committed (incl. in flight), cmt..tail: speculative
  logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [0:0]    state_q, state_d;
  stq_entry_t    mem_q [DEPTH];
  stq_entry_t    head_e;

  logic full, do_push, do_commit;

  assign full      = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign do_commit = commit_i && commit_ready_o;
  // a flush kills the push issued in the same cycle
  assign do_push   = valid_i && !full && !flush_i;

  always_comb begin
    head_d  = head_q;
    cmt_d   = cmt_q;
    tail_d  = tail_q;
    state_d = state_q;
    if (do_commit) cmt_d = cmt_q + PTR_ONE;
    // flush rewinds to the commit pointer as updated this cycle
    if (flush_i)      tail_d = cmt_d;
    else if (do_push) tail_d = tail_q + PTR_ONE;
    case (state_q)
      ST_IDLE:     if (req_o && gnt_i) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_i) begin
        state_d = ST_IDLE;
        head_d  = head_q + PTR_ONE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      cmt_q   <= '0;
      tail_q  <= '0;
      state_q <= ST_IDLE;
    end else begin
      head_q  <= head_d;
      cmt_q   <= cmt_d;
      tail_q  <= tail_d;
      state_q <= state_d;
    end
  end

  // storage needs no reset: only entries between head and tail are ever read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[tail_q[AW-1:0]] <= '{paddr: paddr_i, data: data_i, be: be_i, data_size: data_size_i};
  end

  // status: registered state only
  assign ready_o         = !full;
  assign commit_ready_o  = (cmt_q != tail_q);
  assign no_st_pending_o = (head_q == cmt_q) && (state_q == ST_IDLE);
  assign empty_o         = (head_q == tail_q) && (state_q == ST_IDLE);

  // head entry cannot be overwritten while occupied, so payload holds during req
  assign head_e  = mem_q[head_q[AW-1:0]];
  assign req_o   = (state_q == ST_IDLE) && (head_q != cmt_q);
  assign addr_o  = head_e.paddr;
  assign wdata_o = head_e.data;
  assign be_o    = head_e.be;
  assign size_o  = head_e.data_size;

`ifdef COMMIT_STQ_ALIAS_CHECK_EN
  logic [PW-1:0] occ_cnt;
  logic [AW-1:0] rel;
  logic          unused_po;

  assign occ_cnt   = tail_q - head_q;
  assign unused_po = ^page_offset_i[2:0];

  // an entry is live if its distance from head is below the occupancy count;
  // the in-flight entry sits at head and stays live until ack
  always_comb begin
    page_offset_matches_o = 1'b0;
    rel                   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = AW'(i) - head_q[AW-1:0];
      if (({1'b0, rel} < occ_cnt) && (mem_q[i].paddr[11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
    end
  end
`else
  logic unused_po;
  assign unused_po             = ^page_offset_i;
  // conservative: any buffered store blocks loads
  assign page_offset_matches_o = !empty_o;
`endif

  a_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) (valid_i && !flush_i) |-> ready_o)
    else $warning("store push while queue full was dropped");
  a_commit_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) commit_i |-> commit_ready_o);
  a_ack_idle: assert property (@(posedge clk_i) disable iff (!rst_ni) ack_i |-> (state_q == ST_WAIT_ACK));
  a_gnt_wait: assert property (@(posedge clk_i) disable iff (!rst_ni) gnt_i |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_commit_store_queue.sv
module tb_commit_store_queue;
  import commit_store_queue_pkg::*;

  logic clk, rst_n;
  logic flush [2], valid [2], commit [2], gnt [2], ack [2];
  logic [PLEN-1:0] paddr [2];
  logic [63:0]     wdat [2];
  logic [7:0]      be [2];
  logic [1:0]      sz [2];
  logic [11:0]     pofs;
  logic ready [2], cmt_rdy [2], no_st [2], empty [2], match [2], req [2];
  logic [PLEN-1:0] addr_o [2];
  logic [63:0]     wd_o [2];
  logic [7:0]      be_o [2];
  logic [1:0]      sz_o [2];

  commit_store_queue #(.DEPTH(8)) u_d8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .valid_i(valid[0]), .paddr_i(paddr[0]),
    .data_i(wdat[0]), .be_i(be[0]), .data_size_i(sz[0]), .ready_o(ready[0]), .commit_i(commit[0]),
    .commit_ready_o(cmt_rdy[0]), .no_st_pending_o(no_st[0]), .empty_o(empty[0]), .page_offset_i(pofs),
    .page_offset_matches_o(match[0]), .req_o(req[0]), .addr_o(addr_o[0]), .wdata_o(wd_o[0]),
    .be_o(be_o[0]), .size_o(sz_o[0]), .gnt_i(gnt[0]), .ack_i(ack[0]));

  commit_store_queue #(.DEPTH(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .valid_i(valid[1]), .paddr_i(paddr[1]),
    .data_i(wdat[1]), .be_i(be[1]), .data_size_i(sz[1]), .ready_o(ready[1]), .commit_i(commit[1]),
    .commit_ready_o(cmt_rdy[1]), .no_st_pending_o(no_st[1]), .empty_o(empty[1]), .page_offset_i(pofs),
    .page_offset_matches_o(match[1]), .req_o(req[1]), .addr_o(addr_o[1]), .wdata_o(wd_o[1]),
    .be_o(be_o[1]), .size_o(sz_o[1]), .gnt_i(gnt[1]), .ack_i(ack[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cur = 0, depth = 8, ngrant = 0;
  bit auto_dc = 0;
  // scoreboard: speculative, committed-not-granted, in-flight
  stq_entry_t sq[$], cq[$], infl_e;
  bit infl = 0;

  // one clock: apply D$ responder, check outputs on negedge, advance model
  task automatic step();
    int tot;
    bit e_req, e_full, e_empty, e_match, push_ok;
    stq_entry_t ne, got;
    if (auto_dc) begin gnt[cur] = req[cur]; ack[cur] = infl; end
    @(negedge clk);
    tot     = sq.size() + cq.size() + (infl ? 1 : 0);
    e_req   = !infl && (cq.size() > 0);
    e_full  = (tot == depth);
    e_empty = (tot == 0);
`ifdef COMMIT_STQ_ALIAS_CHECK_EN
    e_match = 0;
    foreach (sq[i]) if (sq[i].paddr[11:3] == pofs[11:3]) e_match = 1;
    foreach (cq[i]) if (cq[i].paddr[11:3] == pofs[11:3]) e_match = 1;
    if (infl && infl_e.paddr[11:3] == pofs[11:3]) e_match = 1;
`else
    e_match = !e_empty;
`endif
    nvec++; if (req[cur] !== e_req) begin nerr++; $display("FAIL req: got %b expected %b t=%0t", req[cur], e_req, $time); end
    nvec++; if (ready[cur] !== !e_full) begin nerr++; $display("FAIL ready: got %b expected %b t=%0t", ready[cur], !e_full, $time); end
    nvec++; if (cmt_rdy[cur] !== (sq.size() > 0)) begin nerr++; $display("FAIL commit_ready: got %b expected %b t=%0t", cmt_rdy[cur], sq.size() > 0, $time); end
    nvec++; if (no_st[cur] !== (cq.size() == 0 && !infl)) begin nerr++; $display("FAIL no_st_pending: got %b expected %b t=%0t", no_st[cur], cq.size() == 0 && !infl, $time); end
    nvec++; if (empty[cur] !== e_empty) begin nerr++; $display("FAIL empty: got %b expected %b t=%0t", empty[cur], e_empty, $time); end
    nvec++; if (match[cur] !== e_match) begin nerr++; $display("FAIL alias: got %b expected %b t=%0t", match[cur], e_match, $time); end
    if (e_req) begin
      got = '{paddr: addr_o[cur], data: wd_o[cur], be: be_o[cur], data_size: sz_o[cur]};
      nvec++; if (got !== cq[0]) begin nerr++; $display("FAIL payload: got %h expected %h t=%0t", got, cq[0], $time); end
    end
    push_ok = valid[cur] && !flush[cur] && !e_full;
    ne = '{paddr: paddr[cur], data: wdat[cur], be: be[cur], data_size: sz[cur]};
    if (e_req && gnt[cur]) begin infl_e = cq.pop_front(); infl = 1; ngrant++; end
    else if (infl && ack[cur]) infl = 0;
    if (commit[cur] && sq.size() > 0) cq.push_back(sq.pop_front());
    if (flush[cur]) sq.delete();
    if (push_ok) sq.push_back(ne);
    @(posedge clk); #1;
  endtask

  task automatic drv(input bit v, input bit c, input bit f, input logic [PLEN-1:0] a);
    valid[cur] = v; commit[cur] = c; flush[cur] = f; paddr[cur] = a;
    wdat[cur] = {a[31:0] ^ 32'hDEADBEEF, a[31:0]};
    be[cur] = a[10:3] ^ 8'hA5; sz[cur] = a[4:3];
    step();
    valid[cur] = 0; commit[cur] = 0; flush[cur] = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sq.size() > 0) drv(0, 1, 0, '0);
    auto_dc = 1;
    while (!(sq.size() == 0 && cq.size() == 0 && !infl && empty[cur]) && n < 100) begin step(); n++; end
    auto_dc = 0; gnt[cur] = 0; ack[cur] = 0;
    nvec++; if (empty[cur] !== 1'b1 || n >= 100) begin nerr++; $display("FAIL drain_timeout: empty %b after %0d cycles, required 1", empty[cur], n); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 0; valid[d] = 0; commit[d] = 0; gnt[d] = 0; ack[d] = 0;
      paddr[d] = '0; wdat[d] = '0; be[d] = '0; sz[d] = '0;
    end
    pofs = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      nvec++; if ({ready[d], cmt_rdy[d], no_st[d], empty[d], req[d]} !== 5'b10110) begin
        nerr++; $display("FAIL reset_status[%0d]: got %b expected 10110", d, {ready[d], cmt_rdy[d], no_st[d], empty[d], req[d]});
      end
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [PLEN-1:0] a = PLEN'(64'h8000_0000);
    cur = 0; depth = 8;
    drv(1, 0, 0, a); drv(1, 0, 0, a + 8); drv(1, 0, 0, a + 16);
    drv(0, 1, 0, '0);
    nvec++; if (req[0] !== 1'b1 || addr_o[0] !== a) begin nerr++; $display("FAIL basic_req: got req %b addr %h expected 1 %h", req[0], addr_o[0], a); end
    gnt[0] = 1; step(); gnt[0] = 0;
    ack[0] = 1; step(); ack[0] = 0;
    nvec++; if (no_st[0] !== 1'b1 || cmt_rdy[0] !== 1'b1) begin nerr++; $display("FAIL basic_status: got no_st %b commit_ready %b expected 1 1", no_st[0], cmt_rdy[0]); end
    drain();
  endtask

  task automatic test_fill();
    int g0;
    cur = 0; depth = 8;
    for (int i = 0; i < 8; i++) drv(1, 0, 0, PLEN'(64'h8000_1000) + PLEN'(i * 8));
    nvec++; if (ready[0] !== 1'b0) begin nerr++; $display("FAIL fill_ready: got %b expected 0", ready[0]); end
    drv(1, 0, 0, PLEN'(64'h8000_1F00));
    g0 = ngrant;
    drain();
    nvec++; if (ngrant - g0 !== 8) begin nerr++; $display("FAIL fill_writes: got %0d expected 8", ngrant - g0); end
  endtask

  task automatic test_flush();
    int g0;
    cur = 0; depth = 8;
    drv(1, 0, 0, PLEN'(64'h8000_2000)); drv(1, 0, 0, PLEN'(64'h8000_2008));
    drv(0, 1, 1, '0);
    nvec++; if (cmt_rdy[0] !== 1'b0 || no_st[0] !== 1'b0) begin nerr++; $display("FAIL flush_split: got commit_ready %b no_st %b expected 0 0", cmt_rdy[0], no_st[0]); end
    g0 = ngrant;
    drain();
    nvec++; if (ngrant - g0 !== 1) begin nerr++; $display("FAIL flush_writes: got %0d expected 1", ngrant - g0); end
  endtask

  task automatic test_stall();
    logic [PLEN-1:0] a = PLEN'(64'h8000_3000);
    cur = 0; depth = 8;
    drv(1, 0, 0, a); drv(0, 1, 0, '0); drv(1, 0, 0, a + 8);
    for (int i = 0; i < 5; i++) begin
      flush[0] = (i == 2);
      step();
      flush[0] = 0;
    end
    nvec++; if (req[0] !== 1'b1 || addr_o[0] !== a || cmt_rdy[0] !== 1'b0) begin
      nerr++; $display("FAIL stall_hold: got req %b addr %h commit_ready %b expected 1 %h 0", req[0], addr_o[0], cmt_rdy[0], a);
    end
    gnt[0] = 1; step(); gnt[0] = 0;
    ack[0] = 1; step(); ack[0] = 0;
    nvec++; if (no_st[0] !== 1'b1 || empty[0] !== 1'b1) begin nerr++; $display("FAIL stall_done: got no_st %b empty %b expected 1 1", no_st[0], empty[0]); end
  endtask

  task automatic test_wrap();
    int npush = 0, nfull = 0, n = 0, g0;
    cur = 1; depth = 4;
    g0 = ngrant;
    auto_dc = 1;
    while (npush < 20 && n < 300) begin
      if (ready[1] === 1'b0) nfull++;
      valid[1] = ready[1]; commit[1] = (sq.size() > 0);
      paddr[1] = PLEN'(64'h8000_4000) + PLEN'(npush * 8);
      wdat[1] = {32'(npush), ~32'(npush)}; be[1] = 8'(npush * 3); sz[1] = 2'(npush);
      if (ready[1] === 1'b1) npush++;
      step();
      valid[1] = 0; commit[1] = 0; n++;
    end
    drain();
    nvec++; if (ngrant - g0 !== 20) begin nerr++; $display("FAIL wrap_writes: got %0d expected 20", ngrant - g0); end
    nvec++; if (nfull == 0) begin nerr++; $display("FAIL wrap_full: got %0d full cycles expected >0", nfull); end
  endtask

  task automatic test_alias();
    cur = 0; depth = 8;
    pofs = 12'h00C;
    drv(1, 0, 0, PLEN'(64'h1008));
    nvec++; if (match[0] !== 1'b1) begin nerr++; $display("FAIL alias_hit: got %b expected 1", match[0]); end
    pofs = 12'h010; #1;
`ifdef COMMIT_STQ_ALIAS_CHECK_EN
    nvec++; if (match[0] !== 1'b0) begin nerr++; $display("FAIL alias_miss: got %b expected 0", match[0]); end
`else
    nvec++; if (match[0] !== 1'b1) begin nerr++; $display("FAIL alias_miss: got %b expected 1", match[0]); end
`endif
    drain();
    nvec++; if (match[0] !== 1'b0) begin nerr++; $display("FAIL alias_empty: got %b expected 0", match[0]); end
    pofs = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_flush();
    test_stall();
    test_wrap();
    test_alias();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
